dadda_mac_accumulator: RTL and testbench

Sequential multiply-accumulate front end that issues operand pairs to the combinational Dadda multiplier and accumulates the products into a wide running sum. It sits directly around the multiplier: it is upstream through the registered operands and downstream through the accumulated product. One accumulated result is handed off per transaction, framed by `in_last`, with valid/ready on both sides.

---
 rtl/dadda_mac_accumulator_pkg.sv | 31 +++
 rtl/dadda_mac_accumulator_if.sv | 40 ++++
 rtl/dadda_mac_accumulator_acc_add.sv | 41 ++++
 rtl/dadda_mac_accumulator.sv | 139 +++++++++++++
 tb/tb_dadda_mac_accumulator.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_mac_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// dadda_pkg
// Shared types and constants for the Dadda multiply-accumulate front end.
//   acc_state_t     : controller states (IDLE, ACCUM, DRAIN, HOLD)
//   RST_STATE       : state entered on reset
//   RST_PVLD        : product-valid flag value on reset
//   acc_width_ok()  : accumulator is wide enough for one full product
//   prod_fits()     : product input fits inside the adder width
// ---------------------------------------------------------------------------
package dadda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

  localparam acc_state_t RST_STATE = IDLE;
  localparam logic       RST_PVLD  = 1'b0;

  // A single WIDTH x WIDTH product is 2*WIDTH bits wide.
  function automatic bit acc_width_ok(input int width, input int accWidth);
    return accWidth >= 2 * width;
  endfunction

  function automatic bit prod_fits(input int prodWidth, input int accWidth);
    return accWidth >= prodWidth;
  endfunction

endpackage

// File: rtl/dadda_mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// dadda_mac_accumulator_if
// Bundles the operand stream, the multiplier connection and the result
// stream of the MAC front end.
//   in_valid/in_ready/in_a/in_b/in_last : operand beats (producer -> block)
//   mul_in1/mul_in2                     : registered operands (block -> mult)
//   mul_prod                            : combinational product (mult -> block)
//   out_valid/out_ready/out_acc/
//   out_count/out_ovf                   : accumulated result (block -> consumer)
// Modports: slave = the accumulator block, master = its environment.
// ---------------------------------------------------------------------------
interface dadda_mac_accumulator_if #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic                   in_last;
  logic [WIDTH-1:0]       mul_in1;
  logic [WIDTH-1:0]       mul_in2;
  logic [2*WIDTH-1:0]     mul_prod;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic [CNT_WIDTH-1:0]   out_count;
  logic                   out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, mul_prod, out_ready,
    output in_ready, mul_in1, mul_in2, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, mul_prod, out_ready,
    input  in_ready, mul_in1, mul_in2, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/dadda_mac_accumulator_acc_add.sv
// ---------------------------------------------------------------------------
// dadda_acc_add
// Adds a zero-extended product to the running accumulator.
//   i_acc  : current accumulator value
//   i_prod : product from the multiplier
//   o_sum  : next accumulator value
//   o_ovf  : carry-out of the ACC_WIDTH-bit add
// Build option DADDA_ACC_SAT_EN: when defined, a carry-out clamps the sum to
// all-ones; otherwise the sum wraps modulo 2^ACC_WIDTH.
// ---------------------------------------------------------------------------
module dadda_acc_add
  import dadda_pkg::*;
#(
  parameter int ACC_WIDTH  = 16,
  parameter int PROD_WIDTH = 8
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [PROD_WIDTH-1:0] i_prod,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_ovf
);

  if (!prod_fits(PROD_WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("dadda_acc_add: ACC_WIDTH must be at least PROD_WIDTH");
  end

  // One extra bit holds the carry-out that flags overflow.
  logic [ACC_WIDTH:0] w_full;

  assign w_full = {1'b0, i_acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, i_prod};
  assign o_ovf  = w_full[ACC_WIDTH];

`ifdef DADDA_ACC_SAT_EN
  // Once saturated, any further non-zero product carries out again, so the
  // accumulator stays pinned at all-ones.
  assign o_sum = w_full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_full[ACC_WIDTH-1:0];
`else
  assign o_sum = w_full[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/dadda_mac_accumulator.sv
// ---------------------------------------------------------------------------
// dadda_mac_accumulator
// Multiply-accumulate front end around an external Dadda multiplier. Operand
// beats are registered onto mul_in1/mul_in2, the returned product is added one
// cycle later, and the sum of a transaction (framed by in_last) is presented
// on the result side until the consumer takes it.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   acc_clr : synchronous abort, overrides everything else
//   bus     : dadda_mac_accumulator_if.slave (operands, multiplier, result)
// Build option DADDA_ACC_SAT_EN selects saturating instead of wrapping sums.
// ---------------------------------------------------------------------------
module dadda_mac_accumulator
  import dadda_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_clr,
  dadda_mac_accumulator_if.slave  bus
);

  if (!acc_width_ok(WIDTH, ACC_WIDTH)) begin : g_width_check
    $error("dadda_mac_accumulator: ACC_WIDTH must be at least 2*WIDTH");
  end

  acc_state_t             r_state;
  acc_state_t             w_nextState;
  logic [WIDTH-1:0]       r_opA;
  logic [WIDTH-1:0]       r_opB;
  logic                   r_pvld;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_ovf;
  logic                   w_inReady;
  logic                   w_outValid;
  logic                   w_accept;
  logic                   w_handoff;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_addOvf;

  // Next state and handshake outputs. DRAIN waits for the final product to be
  // folded in (product-valid high) before presenting the result in HOLD.
  // An abort forces IDLE from any state.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) w_nextState = bus.in_last ? DRAIN : ACCUM;
      end
      ACCUM: begin
        w_inReady = 1'b1;
        if (bus.in_valid && bus.in_last) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (r_pvld) w_nextState = HOLD;
      end
      HOLD: begin
        w_outValid = 1'b1;
        if (bus.out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
    if (acc_clr) w_nextState = IDLE;
  end

  assign w_accept  = bus.in_valid && w_inReady && !acc_clr;
  assign w_handoff = w_outValid && bus.out_ready && !acc_clr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_nextState;
  end

  dadda_acc_add #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PROD_WIDTH (2 * WIDTH)
  ) u_acc_add (
    .i_acc  (r_acc),
    .i_prod (bus.mul_prod),
    .o_sum  (w_sum),
    .o_ovf  (w_addOvf)
  );

  // Datapath. Operands are captured on every accepted beat and survive a
  // handoff so the multiplier input does not glitch between transactions.
  // Product-valid is re-armed by each accepted beat, giving one add per beat
  // one cycle after acceptance. The beat count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opA  <= '0;
      r_opB  <= '0;
      r_pvld <= RST_PVLD;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opA <= bus.in_a;
        r_opB <= bus.in_b;
      end
      if (acc_clr) begin
        r_pvld <= 1'b0;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_ovf  <= 1'b0;
      end else begin
        r_pvld <= w_accept;
        if (w_handoff) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
        end else begin
          if (r_pvld) begin
            r_acc <= w_sum;
            if (w_addOvf) r_ovf <= 1'b1;
          end
          if (w_accept && (r_cnt != {CNT_WIDTH{1'b1}})) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.mul_in1   = r_opA;
  assign bus.mul_in2   = r_opB;
  assign bus.out_acc   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dadda_mac_accumulator
// Directed bench for dadda_mac_accumulator. A 16-bit-accumulator instance
// covers the handshake, latency, stall, abort, count saturation and reset
// cases; an 8-bit-accumulator instance covers wrap/saturate overflow
// (expectation follows DADDA_ACC_SAT_EN). The multiplier is modelled as a
// plain product on each interface.
// ---------------------------------------------------------------------------
module tb_dadda_mac_accumulator;

  logic clk;
  logic rst_n;
  logic acc_clr;
  int   checks;
  int   passes;

  dadda_mac_accumulator_if #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) bus ();
  dadda_mac_accumulator_if #(.WIDTH(4), .ACC_WIDTH(8),  .CNT_WIDTH(8)) bus8 ();

  assign bus.mul_prod  = {4'b0000, bus.mul_in1}  * {4'b0000, bus.mul_in2};
  assign bus8.mul_prod = {4'b0000, bus8.mul_in1} * {4'b0000, bus8.mul_in2};

  dadda_mac_accumulator #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_clr (acc_clr),
    .bus     (bus)
  );

  dadda_mac_accumulator #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc_clr (1'b0),
    .bus     (bus8)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b,
                               input logic last);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  initial begin
    logic [31:0] expAcc8;
`ifdef DADDA_ACC_SAT_EN
    expAcc8 = 32'd255;
`else
    expAcc8 = 32'd194;
`endif
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    acc_clr = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    bus.out_ready = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.in_a = 4'd0;
    bus8.in_b = 4'd0;
    bus8.in_last = 1'b0;
    bus8.out_ready = 1'b0;
    tick();
    tick();

    // Reset values.
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_acc",   32'(bus.out_acc),   32'd0);
    checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
    checkOutput("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    checkOutput("rst_mul_in1",   32'(bus.mul_in1),   32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Single beat 3x5 with last: result two cycles after accept.
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("t1_mul_in1",    32'(bus.mul_in1),   32'd3);
    checkOutput("t1_mul_in2",    32'(bus.mul_in2),   32'd5);
    checkOutput("t1_drain_rdy",  32'(bus.in_ready),  32'd0);
    checkOutput("t1_early_vld",  32'(bus.out_valid), 32'd0);
    tick();
    checkOutput("t1_out_valid",  32'(bus.out_valid), 32'd1);
    checkOutput("t1_out_acc",    32'(bus.out_acc),   32'd15);
    checkOutput("t1_out_count",  32'(bus.out_count), 32'd1);
    checkOutput("t1_out_ovf",    32'(bus.out_ovf),   32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t1_post_vld",   32'(bus.out_valid), 32'd0);
    checkOutput("t1_post_rdy",   32'(bus.in_ready),  32'd1);
    checkOutput("t1_post_acc",   32'(bus.out_acc),   32'd0);
    checkOutput("t1_post_cnt",   32'(bus.out_count), 32'd0);
    checkOutput("t1_keep_op",    32'(bus.mul_in1),   32'd3);

    // Four back-to-back beats: 225 + 6 + 0 + 1 = 232.
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b0);
    tick();
    checkOutput("t2_rdy1",       32'(bus.in_ready),  32'd1);
    applyStimulus(1'b1, 4'd2, 4'd3, 1'b0);
    tick();
    checkOutput("t2_rdy2",       32'(bus.in_ready),  32'd1);
    checkOutput("t2_acc1",       32'(bus.out_acc),   32'd225);
    applyStimulus(1'b1, 4'd0, 4'd9, 1'b0);
    tick();
    checkOutput("t2_acc2",       32'(bus.out_acc),   32'd231);
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("t2_drain_rdy",  32'(bus.in_ready),  32'd0);
    checkOutput("t2_acc3",       32'(bus.out_acc),   32'd231);
    tick();
    checkOutput("t2_out_valid",  32'(bus.out_valid), 32'd1);
    checkOutput("t2_out_acc",    32'(bus.out_acc),   32'd232);
    checkOutput("t2_out_count",  32'(bus.out_count), 32'd4);
    checkOutput("t2_out_ovf",    32'(bus.out_ovf),   32'd0);

    // Stall in HOLD for 5 cycles while the producer keeps offering a beat.
    applyStimulus(1'b1, 4'd7, 4'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_valid",  32'(bus.out_valid), 32'd1);
      checkOutput("hold_rdy",    32'(bus.in_ready),  32'd0);
      checkOutput("hold_acc",    32'(bus.out_acc),   32'd232);
      checkOutput("hold_cnt",    32'(bus.out_count), 32'd4);
    end
    checkOutput("hold_no_load",  32'(bus.mul_in1),   32'd1);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("hs_rdy",        32'(bus.in_ready),  32'd1);
    checkOutput("hs_valid",      32'(bus.out_valid), 32'd0);
    checkOutput("hs_acc",        32'(bus.out_acc),   32'd0);
    checkOutput("hs_cnt",        32'(bus.out_count), 32'd0);
    applyStimulus(1'b1, 4'd1, 4'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("t3_out_valid",  32'(bus.out_valid), 32'd1);
    checkOutput("t3_out_acc",    32'(bus.out_acc),   32'd7);
    checkOutput("t3_out_count",  32'(bus.out_count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Abort after two beats (sum 20), with a beat offered in the abort cycle.
    applyStimulus(1'b1, 4'd2, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd2, 4'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("clr_acc10",     32'(bus.out_acc),   32'd10);
    tick();
    checkOutput("clr_acc20",     32'(bus.out_acc),   32'd20);
    checkOutput("clr_cnt2",      32'(bus.out_count), 32'd2);
    checkOutput("clr_accum_rdy", 32'(bus.in_ready),  32'd1);
    acc_clr = 1'b1;
    applyStimulus(1'b1, 4'd9, 4'd9, 1'b1);
    tick();
    acc_clr = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("clr_acc",       32'(bus.out_acc),   32'd0);
    checkOutput("clr_cnt",       32'(bus.out_count), 32'd0);
    checkOutput("clr_rdy",       32'(bus.in_ready),  32'd1);
    checkOutput("clr_valid",     32'(bus.out_valid), 32'd0);
    checkOutput("clr_no_load",   32'(bus.mul_in1),   32'd2);
    tick();
    tick();
    checkOutput("clr_idle_vld",  32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 4'd2, 4'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("t4_out_valid",  32'(bus.out_valid), 32'd1);
    checkOutput("t4_out_acc",    32'(bus.out_acc),   32'd4);
    checkOutput("t4_out_count",  32'(bus.out_count), 32'd1);
    checkOutput("t4_out_ovf",    32'(bus.out_ovf),   32'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // 300 beats of 1x1: sum 300, count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 4'd1, 4'd1, (i == 299));
      tick();
    end
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("sat_valid",     32'(bus.out_valid), 32'd1);
    checkOutput("sat_count",     32'(bus.out_count), 32'd255);
    checkOutput("sat_acc",       32'(bus.out_acc),   32'd300);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset asserted while in DRAIN.
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("rd_drain_rdy",  32'(bus.in_ready),  32'd0);
    checkOutput("rd_drain_cnt",  32'(bus.out_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rd_cnt",        32'(bus.out_count), 32'd0);
    checkOutput("rd_mul_in1",    32'(bus.mul_in1),   32'd0);
    checkOutput("rd_acc",        32'(bus.out_acc),   32'd0);
    checkOutput("rd_valid",      32'(bus.out_valid), 32'd0);
    checkOutput("rd_rdy",        32'(bus.in_ready),  32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rd_post_vld", 32'(bus.out_valid), 32'd0);
      checkOutput("rd_post_rdy", 32'(bus.in_ready),  32'd1);
    end

    // 8-bit accumulator: 225 + 225 overflows.
    bus8.in_valid = 1'b1;
    bus8.in_a = 4'd15;
    bus8.in_b = 4'd15;
    bus8.in_last = 1'b0;
    tick();
    bus8.in_last = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    bus8.in_last = 1'b0;
    checkOutput("a8_drain_rdy",  32'(bus8.in_ready), 32'd0);
    checkOutput("a8_acc1",       32'(bus8.out_acc),  32'd225);
    checkOutput("a8_ovf1",       32'(bus8.out_ovf),  32'd0);
    tick();
    checkOutput("a8_valid",      32'(bus8.out_valid), 32'd1);
    checkOutput("a8_acc",        32'(bus8.out_acc),   expAcc8);
    checkOutput("a8_ovf",        32'(bus8.out_ovf),   32'd1);
    checkOutput("a8_count",      32'(bus8.out_count), 32'd2);
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    checkOutput("a8_post_acc",   32'(bus8.out_acc),  32'd0);
    checkOutput("a8_post_ovf",   32'(bus8.out_ovf),  32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
